led_pattern_counter: RTL

Parametrised successor to the board LED counter. A prescaler divides clk down to a step tick. On each tick a WIDTH-bit LED pattern advances in one of four run-time modes: binary up, binary down, Gray up, or single-LED bounce. The block adds enable, synchronous load, mode switching, a wrap/reversal flag and selectable output polarity. It sits between the board clock/reset and the LED pins.

---
 rtl/led_pattern_counter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/led_pattern_counter.sv
// Purpose: drives a WIDTH-bit LED pattern that steps once per prescaled tick (binary up/down, Gray up, bounce).
// Latency: tick_o is combinational in the tick cycle; pattern_o/leds_o/wrap_o update on the edge that ends that cycle.
// Backpressure: none; en_i=0 freezes prescaler and pattern, while load and mode change still take effect.
module led_pattern_counter #(
    parameter int TICK_COUNT = 13500000,
    parameter int WIDTH      = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tick_o,
    output logic             wrap_o,
    output logic [WIDTH-1:0] leds_o,
    output logic [WIDTH-1:0] pattern_o
);

    localparam int PW   = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int POSW = $clog2(WIDTH);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_COUNT - 1);
    localparam logic [POSW-1:0]  POS_LAST   = POSW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] VAL_LAST   = WIDTH'(WIDTH - 1);

    localparam logic [1:0] MODE_BIN_UP = 2'b00;
    localparam logic [1:0] MODE_BIN_DN = 2'b01;
    localparam logic [1:0] MODE_GRAY   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [POSW-1:0]  pos_q,   pos_d;
    logic             dir_q,   dir_d;
    logic [1:0]       mode_q,  mode_d;
    logic             wrap_q,  wrap_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;

    logic mode_chg;
    logic tick;
    logic go_down;

    // Next-state: mode change beats load beats tick; outputs are derived from the next state.
    always_comb begin
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        wrap_d    = 1'b0;
        go_down   = dir_q;
        mode_chg  = (mode_i != mode_q);
        tick      = en_i && (presc_q == PRESC_LAST) && !mode_chg && !load_i;

        if (mode_chg) begin
            mode_d  = mode_i;
            presc_d = '0;
            cnt_d   = '0;
            pos_d   = '0;
            dir_d   = 1'b0;
        end else if (load_i) begin
            cnt_d   = load_val_i;
            presc_d = '0;
            pos_d   = (load_val_i >= VAL_LAST) ? POS_LAST : load_val_i[POSW-1:0];
            dir_d   = 1'b0;
        end else if (en_i) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
            if (tick) begin
                case (mode_q)
                    MODE_BIN_DN: begin
                        cnt_d  = cnt_q - WIDTH'(1);
                        wrap_d = (cnt_q == '0);
                    end
                    MODE_BOUNCE: begin
                        // An end position always turns inward, even if a load left dir pointing outward.
                        if (pos_q == POS_LAST) begin
                            go_down = 1'b1;
                        end else if (pos_q == '0) begin
                            go_down = 1'b0;
                        end
                        pos_d = go_down ? pos_q - POSW'(1) : pos_q + POSW'(1);
                        if (pos_d == POS_LAST) begin
                            dir_d  = 1'b1;
                            wrap_d = 1'b1;
                        end else if (pos_d == '0) begin
                            dir_d  = 1'b0;
                            wrap_d = 1'b1;
                        end else begin
                            dir_d  = go_down;
                        end
                    end
                    default: begin
                        cnt_d  = cnt_q + WIDTH'(1);
                        wrap_d = (cnt_q == '1);
                    end
                endcase
            end
        end

        case (mode_d)
            MODE_GRAY:   pattern_d = cnt_d ^ (cnt_d >> 1);
            MODE_BOUNCE: pattern_d = WIDTH'(1) << pos_d;
            default:     pattern_d = cnt_d;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            mode_q    <= MODE_BIN_UP;
            wrap_q    <= 1'b0;
            pattern_q <= '0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            wrap_q    <= wrap_d;
            pattern_q <= pattern_d;
        end
    end

    assign tick_o    = tick;
    assign wrap_o    = wrap_q;
    assign pattern_o = pattern_q;
    assign leds_o    = ACTIVE_LOW ? ~pattern_q : pattern_q;

endmodule
